// File: rtl/fetch_unit.sv
// Fetch unit for the bitty datapath: program store plus PC sequencer that hands one
// instruction at a time to the control unit and waits for its done before advancing.
module fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              done,
  output logic [15:0]       instr,
  output logic              run,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              finished,
  output logic [ADDR_W:0]   retired
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, FIN} state_t;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_L   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  state_t          state, state_nxt;
  logic [15:0]     mem [DEPTH];
  logic [ADDR_W:0] len;
  logic [ADDR_W:0] len_clamp;
  logic            start_ok, start_go, start_nil;
  logic            retire, last, wr_ok;

  // start is only honoured between programs; a zero length skips straight to FIN
  assign start_ok  = start && ((state == IDLE) || (state == FIN));
  assign start_go  = start_ok && (prog_len != '0);
  assign start_nil = start_ok && (prog_len == '0);
  assign len_clamp = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;

  assign retire = (state == ISSUE) && done;
  assign last   = ({1'b0, pc} == (len - ONE_L));
  assign wr_ok  = wr_en && !busy && !reset && ({1'b0, wr_addr} < DEPTH_L);

  // Program store: not cleared by reset, loads blocked while a program runs
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: begin
        if (start_go)       state_nxt = FETCH;
        else if (start_nil) state_nxt = FIN;
      end
      FETCH: state_nxt = ISSUE;
      ISSUE: begin
        if (done) state_nxt = last ? FIN : FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    run      = (state == ISSUE);
    busy     = (state == FETCH) || (state == ISSUE);
    finished = (state == FIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr   <= '0;
      pc      <= '0;
      retired <= '0;
      len     <= '0;
    end else begin
      if (start_go) begin
        len     <= len_clamp;
        pc      <= '0;
        retired <= '0;
      end else if (start_nil) begin
        len     <= '0;
        retired <= '0;
      end
      if (state == FETCH) instr <= mem[pc];
      // pc parks on the last instruction so FIN still reports where the run ended
      if (retire) begin
        if (retired != len) retired <= retired + ONE_L;
        if (!last)          pc      <= pc + ONE_A;
      end
    end
  end

endmodule
